// File: rtl/enigma_step_ctrl_if.sv
// Handshake and datapath bundle for enigma_step_ctrl.
//   master : front end / datapath side (drives cfg, in_valid/in_char,
//            path_result, out_ready)
//   slave  : the step controller (drives in_ready, path_char, positions,
//            out_valid/out_char, char_count)
// Signals:
//   cfg_load, cfg_pos_r/m/l         start-position load (IDLE only)
//   in_valid, in_ready, in_char     plaintext character handshake
//   path_char, pos_r/m/l            drive into the rotor/reflector chain
//   path_result                     settled result from the rotor chain
//   out_valid, out_ready, out_char  enciphered character handshake
//   char_count                      characters completed since reset/load
interface enigma_step_ctrl_if;
  logic        cfg_load;
  logic [4:0]  cfg_pos_r;
  logic [4:0]  cfg_pos_m;
  logic [4:0]  cfg_pos_l;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_char;
  logic [4:0]  path_char;
  logic [4:0]  pos_r;
  logic [4:0]  pos_m;
  logic [4:0]  pos_l;
  logic [4:0]  path_result;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_char;
  logic [15:0] char_count;

  modport master (
    output cfg_load, cfg_pos_r, cfg_pos_m, cfg_pos_l,
    output in_valid, in_char, path_result, out_ready,
    input  in_ready, path_char, pos_r, pos_m, pos_l,
    input  out_valid, out_char, char_count
  );

  modport slave (
    input  cfg_load, cfg_pos_r, cfg_pos_m, cfg_pos_l,
    input  in_valid, in_char, path_result, out_ready,
    output in_ready, path_char, pos_r, pos_m, pos_l,
    output out_valid, out_char, char_count
  );
endinterface

// File: rtl/enigma_step_ctrl.sv
// Three-rotor Enigma step sequencer.
// Owns the rotor positions, steps them once per character (including the
// middle-rotor double step), presents the character and positions to the
// combinational rotor chain, waits SETTLE_CYC cycles, captures the result
// and offers it on a valid/ready output.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous, active-high reset
//   bus  enigma_step_ctrl_if.slave (config, input/output handshakes,
//        rotor datapath drive and result, completed-character count)
//
// State | meaning
// IDLE   | ready for a character or a position load
// STEP   | one cycle: advance rotor positions
// SETTLE | rotor chain settling, counting SETTLE_CYC cycles
// HOLD   | result valid, waiting for out_ready
module enigma_step_ctrl #(
  parameter logic [4:0] NOTCH_R    = 5'd21,
  parameter logic [4:0] NOTCH_M    = 5'd4,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  enigma_step_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STEP   = 2'd1,
    S_SETTLE = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

  state_t      state;
  state_t      state_nx;
  logic [3:0]  settle_cnt;
  logic        settle_done;

  logic        in_ready_c;
  logic        load_en;
  logic        accept_en;
  logic        step_en;
  logic        capture_en;
  logic        release_en;

  logic [4:0]  pos_r_q;
  logic [4:0]  pos_m_q;
  logic [4:0]  pos_l_q;
  logic [4:0]  path_char_q;
  logic [4:0]  out_char_q;
  logic        out_valid_q;
  logic [15:0] char_count_q;

  logic        step_m;
  logic        step_l;

  // Start positions of 26..31 fold back into 0..5.
  function automatic logic [4:0] fold26(input logic [4:0] v);
    return (v >= 5'd26) ? (v - 5'd26) : v;
  endfunction

  function automatic logic [4:0] inc26(input logic [4:0] v);
    return (v == 5'd25) ? 5'd0 : (v + 5'd1);
  endfunction

  assign settle_done = (settle_cnt == SETTLE_LAST);

  // Double step: the middle rotor also advances when it sits on its own
  // notch, dragging the left rotor with it.
  assign step_m = (pos_r_q == NOTCH_R) || (pos_m_q == NOTCH_M);
  assign step_l = (pos_m_q == NOTCH_M);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (!bus.cfg_load && bus.in_valid) state_nx = S_STEP;
      S_STEP:   state_nx = S_SETTLE;
      S_SETTLE: if (settle_done) state_nx = S_HOLD;
      S_HOLD:   if (bus.out_ready) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Output / strobe logic
  always_comb begin
    in_ready_c = 1'b0;
    load_en    = 1'b0;
    accept_en  = 1'b0;
    step_en    = 1'b0;
    capture_en = 1'b0;
    release_en = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready_c = !bus.cfg_load;
        load_en    = bus.cfg_load;
        accept_en  = !bus.cfg_load && bus.in_valid;
      end
      S_STEP:   step_en    = 1'b1;
      S_SETTLE: capture_en = settle_done;
      S_HOLD:   release_en = bus.out_ready;
      default: ;
    endcase
  end

  // Rotor positions and path character
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_r_q     <= 5'd0;
      pos_m_q     <= 5'd0;
      pos_l_q     <= 5'd0;
      path_char_q <= 5'd0;
    end else begin
      if (load_en) begin
        pos_r_q <= fold26(bus.cfg_pos_r);
        pos_m_q <= fold26(bus.cfg_pos_m);
        pos_l_q <= fold26(bus.cfg_pos_l);
      end else if (step_en) begin
        pos_r_q <= inc26(pos_r_q);
        if (step_m) pos_m_q <= inc26(pos_m_q);
        if (step_l) pos_l_q <= inc26(pos_l_q);
      end
      if (accept_en) path_char_q <= bus.in_char;
    end
  end

  // Settle timer
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     settle_cnt <= 4'd0;
    else if (step_en)            settle_cnt <= 4'd0;
    else if (state == S_SETTLE)  settle_cnt <= settle_cnt + 4'd1;
  end

  // Result capture, output handshake and character count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_char_q   <= 5'd0;
      out_valid_q  <= 1'b0;
      char_count_q <= 16'd0;
    end else begin
      if (capture_en) begin
        out_char_q   <= bus.path_result;
        out_valid_q  <= 1'b1;
        char_count_q <= char_count_q + 16'd1;
      end else if (release_en) begin
        out_valid_q  <= 1'b0;
      end
      if (load_en) char_count_q <= 16'd0;
    end
  end

  // in_ready is held low while reset is asserted so every output reads 0.
  assign bus.in_ready   = in_ready_c && !rst;
  assign bus.path_char  = path_char_q;
  assign bus.pos_r      = pos_r_q;
  assign bus.pos_m      = pos_m_q;
  assign bus.pos_l      = pos_l_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_char   = out_char_q;
  assign bus.char_count = char_count_q;

endmodule
